// File: rtl/sat_arith_pkg.sv
// sat_arith_pkg
// Shared signed-saturation helpers for the saturating adder/subtractor pair.
// A result arrives as an exact (w+1)-bit value, sign-extended to 65 bits;
// the helpers decide whether it fits in w bits and clamp it if not.
// Supported widths: 2..63 (the 65-bit carrier must hold w+1 bits plus
// extension).
package sat_arith_pkg;

  // Largest positive value of a w-bit signed number, in a 64-bit carrier.
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative value of a w-bit signed number.
  // Only the low w bits are meaningful; the upper bits are a sign extension.
  function automatic logic [63:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

  // The exact result overflowed upward: the guard bit (w) is 0 and the
  // w-bit sign bit (w-1) is 1.
  function automatic logic sat_is_ovf(input logic [64:0] d, input int w);
    return (((d >> w) & 65'd1) == 65'd0) && (((d >> (w - 1)) & 65'd1) != 65'd0);
  endfunction

  // The exact result overflowed downward: the guard bit is 1 and the
  // w-bit sign bit is 0.
  function automatic logic sat_is_unf(input logic [64:0] d, input int w);
    return (((d >> w) & 65'd1) != 65'd0) && (((d >> (w - 1)) & 65'd1) == 65'd0);
  endfunction

  // Clamped value.  The caller keeps the low w bits.
  function automatic logic [63:0] saturate(input logic [64:0] d, input int w);
    if (sat_is_ovf(d, w)) begin
      return sat_max(w);
    end else if (sat_is_unf(d, w)) begin
      return sat_min(w);
    end
    return d[63:0];
  endfunction

endpackage

// File: rtl/sat_event_counter.sv
// sat_event_counter
// Counts single-cycle events and sticks at its all-ones value instead of
// wrapping.  A clear takes priority over a simultaneous increment.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   clr       clear the count to zero
//   inc       count one event this cycle
//   cnt       current count
module sat_event_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/saturating_sub_pipe.sv
// saturating_sub_pipe
// Streaming signed saturating subtractor: z = clamp(a - b) to WIDTH bits.
// The pipeline has two stages and holds at most two entries.
//   stage 1: exact (WIDTH+1)-bit difference
//   stage 2: clamped result and flags, which drive the outputs directly
// Handshake: data moves on a port when valid & ready are both high in the
// same cycle.  A valid source keeps its data stable until that happens.
//   input side:  in_valid / in_ready.
//                in_ready is combinational from out_ready.
//   output side: out_valid / out_ready.
//                out_valid, z, ovf and unf come straight from registers.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid, in_ready  operand handshake
//   a, b                minuend, subtrahend (signed)
//   out_valid, out_ready  result handshake
//   z                   saturated difference (signed)
//   ovf, unf            z clamped to MAX / MIN
//   clr_cnt, sat_cnt    clear / count of delivered saturated results
module saturating_sub_pipe
  import sat_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] z,
  output logic                    ovf,
  output logic                    unf,
  input  logic                    clr_cnt,
  output logic [CNT_W-1:0]        sat_cnt
);

  logic             s1_valid;
  logic [WIDTH:0]   s1_diff;
  logic [WIDTH:0]   diff_next;
  logic [64:0]      diff_ext;
  logic             s2_load;
  logic             s1_load;
  logic             sat_event;

  // Each stage may load when it is empty or when its current content leaves
  // this cycle.  Because of this, a full pipe can deliver and accept in the
  // same cycle.
  assign s2_load  = ~out_valid | out_ready;
  assign s1_load  = ~s1_valid | s2_load;
  assign in_ready = s1_load;

  // One guard bit makes the difference exact for every operand pair.
  assign diff_next = {a[WIDTH-1], a} - {b[WIDTH-1], b};
  assign diff_ext  = {{(64 - WIDTH){s1_diff[WIDTH]}}, s1_diff};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_diff   <= '0;
      out_valid <= 1'b0;
      z         <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          z   <= WIDTH'(saturate(diff_ext, WIDTH));
          ovf <= sat_is_ovf(diff_ext, WIDTH);
          unf <= sat_is_unf(diff_ext, WIDTH);
        end
      end
      if (s1_load) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_diff <= diff_next;
        end
      end
    end
  end

  // A result is counted only when it is actually handed downstream.
  assign sat_event = out_valid & out_ready & (ovf | unf);

  sat_event_counter #(
    .CNT_W(CNT_W)
  ) u_sat_event_counter (
    .clk(clk),
    .rst(rst),
    .clr(clr_cnt),
    .inc(sat_event),
    .cnt(sat_cnt)
  );

endmodule

// File: tb/tb_saturating_sub_pipe.sv
// tb_saturating_sub_pipe
// Directed bench for saturating_sub_pipe, with WIDTH=8 and CNT_W=4.
// Each scoreboard entry is {z, ovf, unf}.
module tb_saturating_sub_pipe;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic             ovf;
  logic             unf;
  logic             clr_cnt;
  logic [CNT_W-1:0] sat_cnt;

  logic [9:0] exp_q[$];
  int n_cmp;
  int n_bad;
  int stalls;
  int cyc;
  bit stream_mode;
  bit have_last;
  int last_cyc;

  saturating_sub_pipe #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .z(z),
    .ovf(ovf),
    .unf(unf),
    .clr_cnt(clr_cnt),
    .sat_cnt(sat_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got z=0x%0h ovf=%0b unf=%0b expected none", z, ovf, unf);
      end else begin
        check("result", {22'd0, z, ovf, unf}, {22'd0, exp_q.pop_front()});
      end
      if (stream_mode) begin
        if (have_last) check("stream_gap", cyc - last_cyc, 1);
        have_last = 1'b1;
        last_cyc  = cyc;
      end
    end
  end

  // drivers (called at posedge + 1)
  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [9:0] e, input bit push);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
    end else if (push) begin
      exp_q.push_back(e);
    end
    if (waited != 0) stalls++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("wait_out_valid", {31'd0, out_valid}, 1);
  endtask

  initial begin
    int k;
    int vcount;
    logic [7:0] sa[3];
    logic [7:0] sb[3];
    logic [9:0] se[3];
    n_cmp = 0; n_bad = 0; stalls = 0; cyc = 0;
    stream_mode = 0; have_last = 0; last_cyc = 0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1; clr_cnt = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    check("rst_z", {24'd0, z}, 0);
    check("rst_flags", {30'd0, ovf, unf}, 0);
    check("rst_sat_cnt", {28'd0, sat_cnt}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // directed vectors; the first also checks the two-cycle latency
    send(8'd100, 8'h9C, {8'h7F, 2'b10}, 1);
    @(negedge clk);
    check("latency_n1", {31'd0, out_valid}, 0);
    @(negedge clk);
    check("latency_n2", {31'd0, out_valid}, 1);
    @(posedge clk);
    #1;
    send(8'd127, 8'hFF, {8'h7F, 2'b10}, 1);
    send(8'h9C, 8'd100, {8'h80, 2'b01}, 1);
    send(8'h80, 8'd1,   {8'h80, 2'b01}, 1);
    send(8'h80, 8'h80,  {8'h00, 2'b00}, 1);
    send(8'd5,  8'd7,   {8'hFE, 2'b00}, 1);
    drain();

    // back-to-back stream: a = 8i-60, b = i-7 gives z = 7i-53, no clamping
    stalls = 0;
    stream_mode = 1'b1;
    have_last = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send(8'(8 * i - 60), 8'(i - 7), {8'(7 * i - 53), 2'b00}, 1);
    end
    drain();
    stream_mode = 1'b0;
    check("stream_in_ready_stalls", stalls, 0);

    // backpressure: two accepts, then in_ready low and z held
    sa[0] = 8'd10;  sb[0] = 8'd3;   se[0] = {8'h07, 2'b00};
    sa[1] = 8'hCE;  sb[1] = 8'd100; se[1] = {8'h80, 2'b01};
    sa[2] = 8'd1;   sb[2] = 8'd1;   se[2] = {8'h00, 2'b00};
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      a = sa[k];
      b = sb[k];
      @(negedge clk);
      if (c >= 2) begin
        check("stall_in_ready", {31'd0, in_ready}, 0);
        check("stall_out_valid", {31'd0, out_valid}, 1);
        check("stall_z_held", {24'd0, z}, 32'h07);
      end
      if (in_ready) begin
        exp_q.push_back(se[k]);
        k++;
      end
      @(posedge clk);
      #1;
    end
    check("stall_accept_count", k, 2);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // counter saturates at 15
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    @(negedge clk);
    check("cnt_after_clr", {28'd0, sat_cnt}, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) send(8'd100, 8'h9C, {8'h7F, 2'b10}, 1);
    drain();
    check("cnt_saturated", {28'd0, sat_cnt}, 15);

    // reset with both stages full
    out_ready = 1'b0;
    send(8'd20, 8'd1, 10'd0, 0);
    send(8'd30, 8'd1, 10'd0, 0);
    @(negedge clk);
    check("full_in_ready", {31'd0, in_ready}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", {31'd0, out_valid}, 0);
    check("midrst_in_ready", {31'd0, in_ready}, 1);
    check("midrst_sat_cnt", {28'd0, sat_cnt}, 0);
    out_ready = 1'b1;
    vcount = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    check("midrst_no_stale", vcount, 0);
    @(posedge clk);
    #1;

    // count a few, then clear on the same cycle as a saturated delivery
    for (int i = 0; i < 3; i++) send(8'h80, 8'd1, {8'h80, 2'b01}, 1);
    drain();
    check("cnt_three", {28'd0, sat_cnt}, 3);
    out_ready = 1'b0;
    send(8'd100, 8'h9C, {8'h7F, 2'b10}, 1);
    wait_valid();
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    @(negedge clk);
    check("clr_priority", {28'd0, sat_cnt}, 0);
    check("clr_delivered", exp_q.size(), 0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
